// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame, ACK check.
// Optional PS2_TX_RESEND_EN: resend the latched byte up to 2 times on failure.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       err
);

  localparam int MAX_AB = (START_TIMEOUT > XFER_TIMEOUT) ?
                          START_TIMEOUT : XFER_TIMEOUT;
  localparam int MAXP   = (MAX_AB > INHIBIT_CYCLES) ?
                          MAX_AB : INHIBIT_CYCLES;
  localparam int CW     = $clog2(MAXP + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] STO_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] XTO_LAST = CW'(XFER_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_START, S_WAIT,
    S_SHIFT, S_ACK, S_BUS, S_FAIL
  } state_t;

  state_t state_q, state_d;

  logic          c_r0, c_r1, d_r0, d_r1;
  logic          neg, bus_idle;
  logic [CW-1:0] cnt_q;
  logic          cnt_clr;
  logic          inh_done, start_to, xfer_to;
  logic [7:0]    byte_q;
  logic          parity;
  logic          bit_q;
  logic [3:0]    idx_q;
  logic          ack_q;
  logic          accept;
  logic          can_retry;

  assign neg      = c_r1 & ~c_r0;
  assign bus_idle = c_r1 & d_r1;
  assign inh_done = cnt_q >= INH_LAST;
  assign start_to = cnt_q >= STO_LAST;
  assign xfer_to  = cnt_q >= XTO_LAST;
  assign parity   = ~^byte_q;
  assign accept   = (state_q == S_IDLE) & tx_valid;

`ifdef PS2_TX_RESEND_EN
  logic [1:0] retry_q;
  logic       retry;

  assign can_retry = (retry_q != 2'd2);
  assign retry     = (state_d == S_INHIBIT) &&
                     ((state_q == S_BUS) || (state_q == S_FAIL));

  // retry count, restarted by every newly accepted byte
  always_ff @(posedge clk_in) begin
    if (rst)         retry_q <= 2'd0;
    else if (accept) retry_q <= 2'd0;
    else if (retry)  retry_q <= retry_q + 2'd1;
  end
`else
  assign can_retry = 1'b0;
`endif

  // two-flop synchronisers on both pins, idle-high
  always_ff @(posedge clk_in) begin
    if (rst) begin
      c_r0 <= 1'b1;
      c_r1 <= 1'b1;
      d_r0 <= 1'b1;
      d_r1 <= 1'b1;
    end else begin
      c_r0 <= ps2_clk_i;
      c_r1 <= c_r0;
      d_r0 <= ps2_data_i;
      d_r1 <= d_r0;
    end
  end

  // state register
  always_ff @(posedge clk_in) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic; timeouts take priority over clock edges
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (tx_valid) state_d = S_INHIBIT;
      S_INHIBIT: if (inh_done) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT: begin
        if (start_to) state_d = S_FAIL;
        else if (neg) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (xfer_to) state_d = S_FAIL;
        else if (neg && idx_q == 4'd10) state_d = S_ACK;
      end
      S_ACK: begin
        if (xfer_to) state_d = S_FAIL;
        else         state_d = S_BUS;
      end
      S_BUS: begin
        if (xfer_to) state_d = S_FAIL;
        else if (bus_idle)
          state_d = (!ack_q && can_retry) ? S_INHIBIT : S_IDLE;
      end
      S_FAIL:  state_d = can_retry ? S_INHIBIT : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // one shared timer restarts on each phase; SHIFT..BUS share one window
  assign cnt_clr = (state_d != state_q) &&
                   (state_d != S_ACK) && (state_d != S_BUS);

  // saturating phase timer
  always_ff @(posedge clk_in) begin
    if (rst)              cnt_q <= '0;
    else if (cnt_clr)     cnt_q <= '0;
    else if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
  end

  // byte latch, frame bit sequencing and ACK capture
  always_ff @(posedge clk_in) begin
    if (rst) begin
      byte_q <= 8'h00;
      bit_q  <= 1'b1;
      idx_q  <= 4'd0;
      ack_q  <= 1'b0;
    end else begin
      if (accept) byte_q <= tx_data;
      if (state_q == S_WAIT && state_d == S_SHIFT) begin
        bit_q <= byte_q[0];
        idx_q <= 4'd1;
      end
      if (state_q == S_SHIFT && state_d == S_SHIFT && neg) begin
        unique case (1'b1)
          idx_q < 4'd8:  bit_q <= byte_q[idx_q[2:0]];
          idx_q == 4'd8: bit_q <= parity;
          default:       bit_q <= 1'b1;
        endcase
        idx_q <= idx_q + 4'd1;
      end
      if (state_q == S_SHIFT && state_d == S_ACK) ack_q <= ~d_r1;
    end
  end

  // line drive and status outputs decoded from state
  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    done        = 1'b0;
    ack_ok      = 1'b0;
    err         = 1'b0;
    busy        = (state_q != S_IDLE);
    tx_ready    = (state_q == S_IDLE) & ~rst;
    unique case (state_q)
      S_INHIBIT: ps2_clk_oe = 1'b1;
      S_START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      S_WAIT:  ps2_data_oe = 1'b1;
      S_SHIFT: ps2_data_oe = ~bit_q;
      S_BUS: begin
        if (bus_idle && !xfer_to && (ack_q || !can_retry)) begin
          done   = 1'b1;
          ack_ok = ack_q;
          err    = ~ack_q;
        end
      end
      S_FAIL: begin
        if (!can_retry) begin
          done = 1'b1;
          err  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model plus done-driven scoreboard.
// Frames are hand-computed {stop, parity, byte} constants.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int STO = 300;
  localparam int XTO = 3000;
  localparam int H   = 10;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe;
  logic       busy, done, ack_ok, err;
  logic       ps2_clk_i, ps2_data_i;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (STO),
    .XFER_TIMEOUT  (XTO)
  ) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_data_i (ps2_data_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .err        (err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic       ack;
    logic       er;
    logic [9:0] frame;
    bit         chkw;
  } exp_t;

  exp_t       sbq[$];
  int         total = 0;
  int         bad = 0;
  logic [9:0] dev_bits = '0;
  int         inh_cnt = 0;
  logic       last_doe = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input logic a, input logic e,
                      input logic [9:0] f, input bit w);
    exp_t x;
    x.ack = a;
    x.er = e;
    x.frame = f;
    x.chkw = w;
    sbq.push_back(x);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk_in);
    chk("ready_before_send", tx_ready, 1);
    tx_valid = 1'b1;
    tx_data = d;
    @(negedge clk_in);
    tx_valid = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < lim) begin
      @(negedge clk_in);
      n++;
    end
    chk("idle_wait", busy, 0);
  endtask

  // device side: wait for request-to-send, clock nfall pulses
  task automatic dev_frame(input bit ack, input int nfall);
    int n;
    n = 0;
    while (ps2_clk_i !== 1'b0 && n < 200) begin
      @(negedge clk_in);
      n++;
    end
    n = 0;
    while (!(ps2_clk_i === 1'b1 && ps2_data_i === 1'b0) && n < 1000) begin
      @(negedge clk_in);
      n++;
    end
    chk("rts_release", {ps2_clk_i, ps2_data_i}, 2'b10);
    repeat (5) @(negedge clk_in);
    for (int k = 1; k <= nfall; k++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk_in);
      dev_clk_low = 1'b0;
      if (k <= 10) dev_bits[k-1] = ps2_data_i;
      repeat (H / 2) @(negedge clk_in);
      if (k == 10) dev_data_low = ack;
      repeat (H / 2) @(negedge clk_in);
    end
    dev_data_low = 1'b0;
  endtask

  exp_t e;

  // scoreboard monitor: pop one expectation per done pulse
  always @(negedge clk_in) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done ack_ok=%0d err=%0d", ack_ok, err);
      end else begin
        e = sbq.pop_front();
        chk("ack_ok", ack_ok, e.ack);
        chk("err", err, e.er);
        chk("oe_at_done", {ps2_clk_oe, ps2_data_oe}, 0);
        if (e.chkw) chk("wire_frame", dev_bits, e.frame);
      end
    end
  end

  // request-to-send shape: clock low INH+1 cycles, start bit at release
  always @(negedge clk_in) begin
    if (rst) begin
      inh_cnt = 0;
    end else if (ps2_clk_oe) begin
      inh_cnt++;
      last_doe = ps2_data_oe;
    end else if (inh_cnt != 0) begin
      chk("inhibit_len", inh_cnt, INH + 1);
      chk("start_before_release", last_doe, 1);
      chk("start_after_release", ps2_data_oe, 1);
      inh_cnt = 0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_in);
    chk("reset_outputs",
        {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, ack_ok, err}, 0);
    rst = 1'b0;
    @(negedge clk_in);
    chk("ready_after_reset", tx_ready, 1);

    push(1'b1, 1'b0, 10'h3ED, 1'b1);
    send(8'hED);
    dev_frame(1'b1, 11);
    wait_idle(500);
    chk("sb_drained_ed", sbq.size(), 0);

    push(1'b1, 1'b0, 10'h2F4, 1'b1);
    send(8'hF4);
    dev_frame(1'b1, 11);
    wait_idle(500);
    chk("sb_drained_f4", sbq.size(), 0);

    push(1'b0, 1'b1, 10'h33C, 1'b1);
    send(8'h3C);
`ifdef PS2_TX_RESEND_EN
    repeat (3) dev_frame(1'b0, 11);
`else
    dev_frame(1'b0, 11);
`endif
    wait_idle(500);
    chk("sb_drained_nack", sbq.size(), 0);

    push(1'b0, 1'b1, 10'h000, 1'b0);
    send(8'hA5);
    wait_idle(4000);
    chk("ready_after_fail", tx_ready, 1);
    chk("sb_drained_timeout", sbq.size(), 0);

    push(1'b1, 1'b0, 10'h3FF, 1'b1);
    send(8'hFF);
    fork
      dev_frame(1'b1, 11);
      begin
        repeat (80) @(negedge clk_in);
        tx_valid = 1'b1;
        tx_data = 8'h55;
        @(negedge clk_in);
        chk("ready_while_busy", tx_ready, 0);
        tx_valid = 1'b0;
      end
    join
    wait_idle(500);
    repeat (10) @(negedge clk_in);
    chk("no_queued_send", busy, 0);
    chk("sb_drained_ff", sbq.size(), 0);

    send(8'hED);
    dev_frame(1'b1, 5);
    rst = 1'b1;
    @(negedge clk_in);
    chk("rst_mid_xfer", {ps2_clk_oe, ps2_data_oe, busy, done}, 0);
    rst = 1'b0;
    @(negedge clk_in);
    chk("ready_after_mid_rst", tx_ready, 1);

    push(1'b1, 1'b0, 10'h3ED, 1'b1);
    send(8'hED);
    dev_frame(1'b1, 11);
    wait_idle(500);
    repeat (20) @(negedge clk_in);
    chk("sb_drained_final", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
